decode_stage_pipe: RTL

- Registered successor to the combinational instruction decoder; sits between IF/ID and EX.
- Decodes one 32-bit MIPS-subset instruction per accepted transfer into the ALU code and control bundle, and holds it in an ID/EX pipeline register.
- Adds a valid/ready handshake, load-use hazard bubble insertion, synchronous flush, deterministic decode of unknown opcodes, a separate BLTZ encoding and a saturating stall counter.

---
 rtl/decode_stage_pipe.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// ID/EX stage: decodes one MIPS-subset instruction per accepted transfer into an ALU code and control bundle.
// Optional illegal-instruction flag enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_stage_pipe #(
   parameter int unsigned PC_W        = 32,
   parameter int unsigned ALUCODE_W   = 5,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [PC_W-1:0]        in_pc,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_W-1:0]        out_pc,
   output logic [31:0]            out_instr,
   output logic [ALUCODE_W-1:0]   out_alucode,
   output logic [10:0]            out_ctrl,
   output logic [4:0]             out_wreg,
`ifdef DECODE_ILLEGAL_TRAP_EN
   output logic [STALL_CNT_W-1:0] stall_count,
   output logic                   illegal_instr
`else
   output logic [STALL_CNT_W-1:0] stall_count
`endif
);

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,  ALU_AND  = 5'd1,  ALU_XOR  = 5'd2,  ALU_OR   = 5'd3,
      ALU_NOR  = 5'd4,  ALU_SUB  = 5'd5,  ALU_ANDI = 5'd6,  ALU_XORI = 5'd7,
      ALU_ORI  = 5'd8,  ALU_JR   = 5'd9,  ALU_BEQ  = 5'd10, ALU_BNE  = 5'd11,
      ALU_BGEZ = 5'd12, ALU_BGTZ = 5'd13, ALU_BLEZ = 5'd14, ALU_BLTZ = 5'd15,
      ALU_SLL  = 5'd16, ALU_SRL  = 5'd17, ALU_SRA  = 5'd18, ALU_SLT  = 5'd19,
      ALU_SLTU = 5'd20
   } alu_e;

   // {regwrite, memtoreg, memwrite, memread, alusrca, alusrcb, regdst, branch, j, jr, uses_rt}
   localparam logic [10:0] C_RALU  = 11'b1_0_0_0_0_0_1_0_0_0_1;
   localparam logic [10:0] C_SHIMM = 11'b1_0_0_0_1_0_1_0_0_0_1;
   localparam logic [10:0] C_JR    = 11'b0_0_0_0_0_0_0_0_0_1_1;
   localparam logic [10:0] C_IALU  = 11'b1_0_0_0_0_1_0_0_0_0_0;
   localparam logic [10:0] C_LW    = 11'b1_1_0_1_0_1_0_0_0_0_0;
   localparam logic [10:0] C_SW    = 11'b0_0_1_0_0_1_0_0_0_0_1;
   localparam logic [10:0] C_BRRT  = 11'b0_0_0_0_0_0_0_1_0_0_1;
   localparam logic [10:0] C_BR    = 11'b0_0_0_0_0_0_0_1_0_0_0;
   localparam logic [10:0] C_J     = 11'b0_0_0_0_0_0_0_0_1_0_0;

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd;
   assign op    = in_instr[31:26];
   assign rs    = in_instr[25:21];
   assign rt    = in_instr[20:16];
   assign rd    = in_instr[15:11];
   assign funct = in_instr[5:0];

   alu_e                 code;
   logic [10:0]          raw_ctrl;
   logic                 dec_illegal;
   logic [10:0]          dec_ctrl;
   logic [ALUCODE_W-1:0] dec_alucode;
   logic [4:0]           dec_wreg;

   always_comb begin
      code        = ALU_ADD;
      raw_ctrl    = '0;
      dec_illegal = 1'b0;
      if (in_instr != '0) begin
         unique case (op)
            6'h00: begin
               unique case (funct)
                  6'h20, 6'h21: begin code = ALU_ADD;  raw_ctrl = C_RALU;  end
                  6'h22, 6'h23: begin code = ALU_SUB;  raw_ctrl = C_RALU;  end
                  6'h24:        begin code = ALU_AND;  raw_ctrl = C_RALU;  end
                  6'h25:        begin code = ALU_OR;   raw_ctrl = C_RALU;  end
                  6'h26:        begin code = ALU_XOR;  raw_ctrl = C_RALU;  end
                  6'h27:        begin code = ALU_NOR;  raw_ctrl = C_RALU;  end
                  6'h2A:        begin code = ALU_SLT;  raw_ctrl = C_RALU;  end
                  6'h2B:        begin code = ALU_SLTU; raw_ctrl = C_RALU;  end
                  6'h00:        begin code = ALU_SLL;  raw_ctrl = C_SHIMM; end
                  6'h02:        begin code = ALU_SRL;  raw_ctrl = C_SHIMM; end
                  6'h03:        begin code = ALU_SRA;  raw_ctrl = C_SHIMM; end
                  6'h04:        begin code = ALU_SLL;  raw_ctrl = C_RALU;  end
                  6'h06:        begin code = ALU_SRL;  raw_ctrl = C_RALU;  end
                  6'h07:        begin code = ALU_SRA;  raw_ctrl = C_RALU;  end
                  6'h08:        begin code = ALU_JR;   raw_ctrl = C_JR;    end
                  default:      dec_illegal = 1'b1;
               endcase
            end
            6'h08, 6'h09: begin code = ALU_ADD;  raw_ctrl = C_IALU; end
            6'h0A:        begin code = ALU_SLT;  raw_ctrl = C_IALU; end
            6'h0B:        begin code = ALU_SLTU; raw_ctrl = C_IALU; end
            6'h0C:        begin code = ALU_ANDI; raw_ctrl = C_IALU; end
            6'h0D:        begin code = ALU_ORI;  raw_ctrl = C_IALU; end
            6'h0E:        begin code = ALU_XORI; raw_ctrl = C_IALU; end
            6'h23:        begin code = ALU_ADD;  raw_ctrl = C_LW;   end
            6'h2B:        begin code = ALU_ADD;  raw_ctrl = C_SW;   end
            6'h04:        begin code = ALU_BEQ;  raw_ctrl = C_BRRT; end
            6'h05:        begin code = ALU_BNE;  raw_ctrl = C_BRRT; end
            6'h06:        begin code = ALU_BLEZ; raw_ctrl = C_BR;   end
            6'h07:        begin code = ALU_BGTZ; raw_ctrl = C_BR;   end
            6'h01: begin
               if (rt == 5'd1)      begin code = ALU_BGEZ; raw_ctrl = C_BR; end
               else if (rt == 5'd0) begin code = ALU_BLTZ; raw_ctrl = C_BR; end
               else                 dec_illegal = 1'b1;
            end
            6'h02:        begin code = ALU_ADD;  raw_ctrl = C_J;    end
            default:      dec_illegal = 1'b1;
         endcase
      end
   end

   // Unknown words always decode to zero controls so nothing downstream can fire.
   always_comb begin
      dec_ctrl         = dec_illegal ? 11'b0 : raw_ctrl;
      dec_alucode      = '0;
      dec_alucode[4:0] = dec_illegal ? ALU_ADD : code;
      dec_wreg         = dec_ctrl[10] ? (dec_ctrl[4] ? rd : rt) : 5'd0;
   end

   logic                   valid_q, valid_d;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic [31:0]            instr_q, instr_d;
   logic [ALUCODE_W-1:0]   alucode_q, alucode_d;
   logic [10:0]            ctrl_q, ctrl_d;
   logic [4:0]             wreg_q, wreg_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic                   ill_q, ill_d;
   logic                   hazard, accept;

   assign hazard = valid_q & ctrl_q[7] & (wreg_q != 5'd0) & in_valid &
                   ((wreg_q == rs) | (dec_ctrl[0] & (wreg_q == rt)));
   assign in_ready = rst_n & ~flush & ~hazard & (~valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      alucode_d = alucode_q;
      ctrl_d    = ctrl_q;
      wreg_d    = wreg_q;
      stall_d   = stall_q;
      ill_d     = ill_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         pc_d      = in_pc;
         instr_d   = in_instr;
         alucode_d = dec_alucode;
         ctrl_d    = dec_ctrl;
         wreg_d    = dec_wreg;
         ill_d     = dec_illegal;
      end else if (out_ready && valid_q) begin
         // Draining while the hazard holds off the consumer is the bubble.
         valid_d = 1'b0;
         if (hazard && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         instr_q   <= '0;
         alucode_q <= '0;
         ctrl_q    <= '0;
         wreg_q    <= '0;
         stall_q   <= '0;
         ill_q     <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         alucode_q <= alucode_d;
         ctrl_q    <= ctrl_d;
         wreg_q    <= wreg_d;
         stall_q   <= stall_d;
         ill_q     <= ill_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_pc      = pc_q;
   assign out_instr   = instr_q;
   assign out_alucode = alucode_q;
   assign out_ctrl    = ctrl_q;
   assign out_wreg    = wreg_q;
   assign stall_count = stall_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
   assign illegal_instr = ill_q;
`else
   logic unused_ill;
   assign unused_ill = ill_q;
`endif

endmodule
